traffic_phase_timer: RTL

//  Timing stage directly upstream of the intersection light controller. Divides clk to a
//  1-second tick and dwells in each signal phase for a programmed number of ticks.

---
 rtl/traffic_phase_timer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/traffic_phase_timer.sv
// Phase timer feeding the intersection light controller: 1-second prescaler plus phase dwell FSM.
// Optional ALL_RED clearance phase after each yellow is enabled by defining TRAFFIC_ALL_RED_EN.
module traffic_phase_timer #(
  parameter int CLK_DIV     = 50_000_000,
  parameter int GREEN_TIME  = 30,
  parameter int YELLOW_TIME = 5,
  parameter int ALLRED_TIME = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic [2:0] phase,
  output logic       phase_advance,
  output logic [7:0] remaining,
  output logic       tick
);

  localparam int            PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] DIV_LAST = PW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    EW_GREEN  = 3'd2,
    EW_YELLOW = 3'd3,
    ALL_RED   = 3'd4
  } phase_t;

`ifdef TRAFFIC_ALL_RED_EN
  localparam logic [2:0] MAX_PHASE = 3'd4;
`else
  localparam logic [2:0] MAX_PHASE = 3'd3;
`endif

  // Reload value for a phase is its duration minus one; the counter reloads at zero so it never wraps.
  function automatic logic [7:0] dwell_m1(input phase_t p);
    case (p)
      NS_YELLOW, EW_YELLOW: dwell_m1 = 8'(YELLOW_TIME - 1);
      ALL_RED:              dwell_m1 = 8'(ALLRED_TIME - 1);
      default:              dwell_m1 = 8'(GREEN_TIME - 1);
    endcase
  endfunction

  logic [PW-1:0] r_presc;
  logic          r_tick;
  phase_t        r_phase;
  phase_t        w_phase_nxt;
  logic [7:0]    r_remaining;
  logic [7:0]    w_remaining_nxt;
  logic          r_adv;
  logic          w_adv_nxt;
  logic          w_tick_now;
  logic          w_phase_legal;
`ifdef TRAFFIC_ALL_RED_EN
  logic          r_dir;      // 0 = NS green follows ALL_RED, 1 = EW green follows
  logic          w_dir_nxt;
`endif

  assign w_tick_now    = enable && (r_presc == DIV_LAST);
  assign w_phase_legal = (3'(r_phase) <= MAX_PHASE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= w_tick_now;
      if (enable) begin
        if (r_presc == DIV_LAST) r_presc <= '0;
        else                     r_presc <= r_presc + 1'b1;
      end
    end
  end

  always_comb begin
    w_phase_nxt     = r_phase;
    w_remaining_nxt = r_remaining;
    w_adv_nxt       = 1'b0;
`ifdef TRAFFIC_ALL_RED_EN
    w_dir_nxt       = r_dir;
`endif
    if (!w_phase_legal) begin
      // Recover from a corrupted phase register regardless of enable.
      w_phase_nxt     = NS_GREEN;
      w_remaining_nxt = dwell_m1(NS_GREEN);
      w_adv_nxt       = 1'b1;
`ifdef TRAFFIC_ALL_RED_EN
      w_dir_nxt       = 1'b0;
`endif
    end else if (w_tick_now) begin
      if (r_remaining != 8'd0) begin
        w_remaining_nxt = r_remaining - 8'd1;
      end else begin
        w_adv_nxt = 1'b1;
        case (r_phase)
          NS_GREEN:  w_phase_nxt = NS_YELLOW;
          EW_GREEN:  w_phase_nxt = EW_YELLOW;
`ifdef TRAFFIC_ALL_RED_EN
          NS_YELLOW: begin
            w_phase_nxt = ALL_RED;
            w_dir_nxt   = 1'b1;
          end
          EW_YELLOW: begin
            w_phase_nxt = ALL_RED;
            w_dir_nxt   = 1'b0;
          end
          ALL_RED:   w_phase_nxt = r_dir ? EW_GREEN : NS_GREEN;
`else
          NS_YELLOW: w_phase_nxt = EW_GREEN;
          EW_YELLOW: w_phase_nxt = NS_GREEN;
`endif
          default:   w_phase_nxt = NS_GREEN;
        endcase
        w_remaining_nxt = dwell_m1(w_phase_nxt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase     <= NS_GREEN;
      r_remaining <= 8'(GREEN_TIME - 1);
      r_adv       <= 1'b0;
`ifdef TRAFFIC_ALL_RED_EN
      r_dir       <= 1'b0;
`endif
    end else begin
      r_phase     <= w_phase_nxt;
      r_remaining <= w_remaining_nxt;
      r_adv       <= w_adv_nxt;
`ifdef TRAFFIC_ALL_RED_EN
      r_dir       <= w_dir_nxt;
`endif
    end
  end

  assign phase         = 3'(r_phase);
  assign phase_advance = r_adv;
  assign remaining     = r_remaining;
  assign tick          = r_tick;

endmodule
